// File: rtl/e1_track_epoch_ctrl_pkg.sv
// Shared tracking definitions: epoch-controller state encoding and default sizing.
package e1_track_epoch_ctrl_pkg;

    localparam int DSIZE_DEF     = 32;
    localparam int NUM_ACCUM_DEF = 6;
    localparam int CNT_W_DEF     = 16;
    localparam int ACC_LAT_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/e1_track_epoch_ctrl.sv
// Integration-epoch controller: gates mixer samples into the resampler for N samples,
// waits for the accumulators to settle, then holds the latched I/Q results until consumed.
module e1_track_epoch_ctrl
    import e1_track_epoch_ctrl_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int NUM_ACCUM = NUM_ACCUM_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ACC_LAT   = ACC_LAT_DEF
) (
    input  logic                       axis_aclk,
    input  logic                       axis_aresetn,
    input  logic                       i_cfg_valid,
    output logic                       o_cfg_ready,
    input  logic [CNT_W-1:0]           i_samples_per_epoch,
    input  logic                       i_continuous,
    input  logic                       i_abort,
    input  logic                       i_mixed_signal_valid,
    output logic                       o_sample_valid,
    output logic                       o_start_tracking_valid,
    output logic                       o_clear,
    output logic                       o_clear_accum,
    input  logic [NUM_ACCUM*DSIZE-1:0] i_accum_i,
    input  logic [NUM_ACCUM*DSIZE-1:0] i_accum_q,
    output logic [NUM_ACCUM*DSIZE-1:0] o_epoch_i,
    output logic [NUM_ACCUM*DSIZE-1:0] o_epoch_q,
    output logic                       o_epoch_valid,
    input  logic                       i_epoch_ready,
    output logic [CNT_W-1:0]           o_epoch_cnt,
    output logic                       o_dropped,
    output logic                       o_busy
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ACC_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] count;
    logic             live;
    logic             in_run;
    logic             cfg_fire;
    logic             last_sample;

    // live stays low through reset so the config handshake opens one edge after release
    assign in_run                 = (state == ST_RUN);
    assign o_cfg_ready            = live && (state == ST_IDLE);
    assign cfg_fire               = i_cfg_valid && o_cfg_ready;
    assign o_sample_valid         = in_run && i_mixed_signal_valid;
    assign o_dropped              = live && !in_run && i_mixed_signal_valid;
    assign o_start_tracking_valid = (state == ST_START);
    assign o_clear_accum          = in_run || (state == ST_DRAIN) || (state == ST_HOLD);
    assign o_busy                 = (state != ST_IDLE);
    assign last_sample            = (count == n_reg - CNT_W'(1));

    // count doubles as the sample counter in RUN and the settle timer in DRAIN
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= ST_IDLE;
            n_reg         <= '0;
            count         <= '0;
            o_epoch_cnt   <= '0;
            o_epoch_i     <= '0;
            o_epoch_q     <= '0;
            o_epoch_valid <= 1'b0;
            o_clear       <= 1'b0;
            live          <= 1'b0;
        end else begin
            live    <= 1'b1;
            o_clear <= 1'b0;
            if (i_abort) begin
                state         <= ST_IDLE;
                o_epoch_valid <= 1'b0;
                o_clear       <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (cfg_fire && (i_samples_per_epoch != '0)) begin
                            n_reg <= i_samples_per_epoch;
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        count <= '0;
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (i_mixed_signal_valid) begin
                            if (last_sample) begin
                                count <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (count == DRAIN_LAST) begin
                            o_epoch_i     <= i_accum_i;
                            o_epoch_q     <= i_accum_q;
                            o_epoch_valid <= 1'b1;
                            state         <= ST_HOLD;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (i_epoch_ready) begin
                            o_epoch_valid <= 1'b0;
                            o_epoch_cnt   <= o_epoch_cnt + CNT_W'(1);
                            state         <= i_continuous ? ST_START : ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_e1_track_epoch_ctrl.sv
// Bench for e1_track_epoch_ctrl: directed epochs checked against an epoch-level model every cycle.
module tb_e1_track_epoch_ctrl;

    localparam int DSIZE   = 32;
    localparam int NA      = 6;
    localparam int CNT_W   = 16;
    localparam int ACC_LAT = 2;
    localparam int AW      = NA * DSIZE;

    localparam int M_IDLE  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;
    localparam int M_HOLD  = 4;

    localparam logic [AW-1:0] EXP_I1 = {32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11};
    localparam logic [AW-1:0] EXP_Q1 = {32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21};
    localparam logic [AW-1:0] EXP_I2 = {32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31};

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] spe = '0;
    logic             cont = 1'b0;
    logic             abort = 1'b0;
    logic             msv = 1'b0;
    logic             sample_valid, start_valid, clear, clear_accum;
    logic [AW-1:0]    acc_i = '0;
    logic [AW-1:0]    acc_q = '0;
    logic [AW-1:0]    epoch_i, epoch_q;
    logic             epoch_valid;
    logic             epoch_ready = 1'b0;
    logic [CNT_W-1:0] epoch_cnt;
    logic             dropped, busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    e1_track_epoch_ctrl #(
        .DSIZE(DSIZE), .NUM_ACCUM(NA), .CNT_W(CNT_W), .ACC_LAT(ACC_LAT)
    ) dut (
        .axis_aclk              (clk),
        .axis_aresetn           (rst_n),
        .i_cfg_valid            (cfg_valid),
        .o_cfg_ready            (cfg_ready),
        .i_samples_per_epoch    (spe),
        .i_continuous           (cont),
        .i_abort                (abort),
        .i_mixed_signal_valid   (msv),
        .o_sample_valid         (sample_valid),
        .o_start_tracking_valid (start_valid),
        .o_clear                (clear),
        .o_clear_accum          (clear_accum),
        .i_accum_i              (acc_i),
        .i_accum_q              (acc_q),
        .o_epoch_i              (epoch_i),
        .o_epoch_q              (epoch_q),
        .o_epoch_valid          (epoch_valid),
        .i_epoch_ready          (epoch_ready),
        .o_epoch_cnt            (epoch_cnt),
        .o_dropped              (dropped),
        .o_busy                 (busy)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_bus(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Epoch-level model: samples remaining and settle cycles remaining, counted down.
    int               m_mode = M_IDLE;
    int               m_left = 0;
    int               m_drain = 0;
    logic             m_live = 1'b0;
    logic             m_clr = 1'b0;
    logic             m_ev = 1'b0;
    logic [CNT_W-1:0] m_n = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [AW-1:0]    m_ei = '0;
    logic [AW-1:0]    m_eq = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_left <= 0; m_drain <= 0; m_live <= 1'b0; m_clr <= 1'b0;
            m_ev <= 1'b0; m_n <= '0; m_cnt <= '0; m_ei <= '0; m_eq <= '0;
        end else begin
            m_live <= 1'b1;
            m_clr  <= abort;
            if (abort) begin
                m_mode <= M_IDLE;
                m_ev   <= 1'b0;
            end else if (m_mode == M_IDLE) begin
                if (m_live && cfg_valid && spe != '0) begin
                    m_n    <= spe;
                    m_mode <= M_START;
                end
            end else if (m_mode == M_START) begin
                m_left <= int'(m_n);
                m_mode <= M_RUN;
            end else if (m_mode == M_RUN) begin
                if (msv) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_drain <= ACC_LAT;
                        m_mode  <= M_DRAIN;
                    end
                end
            end else if (m_mode == M_DRAIN) begin
                m_drain <= m_drain - 1;
                if (m_drain == 1) begin
                    m_ei   <= acc_i;
                    m_eq   <= acc_q;
                    m_ev   <= 1'b1;
                    m_mode <= M_HOLD;
                end
            end else if (m_mode == M_HOLD) begin
                if (epoch_ready) begin
                    m_ev   <= 1'b0;
                    m_cnt  <= m_cnt + 16'd1;
                    m_mode <= cont ? M_START : M_IDLE;
                end
            end
        end
    end

    always @(negedge clk) begin
        check_bit("cfg_ready", cfg_ready, m_live && m_mode == M_IDLE);
        check_bit("busy", busy, m_mode != M_IDLE);
        check_bit("start_pulse", start_valid, m_mode == M_START);
        check_bit("sample_valid", sample_valid, m_mode == M_RUN && msv);
        check_bit("dropped", dropped, m_live && msv && m_mode != M_RUN);
        check_bit("clear", clear, m_clr);
        check_bit("epoch_valid", epoch_valid, m_ev);
        check_int("epoch_cnt", int'(epoch_cnt), int'(m_cnt));
        check_bus("epoch_i", epoch_i, m_ei);
        check_bus("epoch_q", epoch_q, m_eq);
        if (m_mode != M_HOLD)
            check_bit("clear_accum", clear_accum, m_mode == M_RUN || m_mode == M_DRAIN);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_accum(input int bi, input int bq);
        for (int k = 0; k < NA; k++) begin
            acc_i[k*DSIZE +: DSIZE] = DSIZE'(bi + k);
            acc_q[k*DSIZE +: DSIZE] = DSIZE'(bq + k);
        end
    endtask

    task automatic do_cfg(input int n);
        cfg_valid = 1'b1;
        spe = CNT_W'(n);
        #1 check_bit("cfg_ready_at_cfg", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_samples(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            msv = 1'b1;
            #1 seen += int'(sample_valid);
            tick();
        end
        msv = 1'b0;
        check_int("forwarded", seen, n);
    endtask

    task automatic wait_epoch();
        int k = 1;
        while (!epoch_valid && k < 20) begin
            tick();
            k++;
        end
        check_int("epoch_latency", k, 1 + ACC_LAT);
    endtask

    task automatic handshake();
        epoch_ready = 1'b1;
        tick();
        epoch_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", passes, checks);
        $fatal(1);
    end

    initial begin
        int drops;
        logic ev_seen;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_bit("rst_cfg_ready", cfg_ready, 1'b0);
        check_bit("rst_clear_accum", clear_accum, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #1 check_bit("ready_before_edge", cfg_ready, 1'b0);
        tick();
        check_bit("ready_after_release", cfg_ready, 1'b1);

        // basic epoch, N=4
        set_accum(32'h11, 32'h21);
        do_cfg(4);
        check_bit("basic_start", start_valid, 1'b1);
        tick();
        check_bit("basic_start_once", start_valid, 1'b0);
        send_samples(4);
        wait_epoch();
        check_bus("basic_epoch_i", epoch_i, EXP_I1);
        check_bus("basic_epoch_q", epoch_q, EXP_Q1);
        check_int("basic_cnt_before", int'(epoch_cnt), 0);
        handshake();
        check_int("basic_cnt_after", int'(epoch_cnt), 1);
        check_bit("basic_idle", busy, 1'b0);

        // back-pressure with continuous restart
        set_accum(32'h31, 32'h41);
        cont = 1'b1;
        do_cfg(3);
        tick();
        send_samples(3);
        wait_epoch();
        set_accum(32'h51, 32'h61);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            msv = (i % 2 == 0);
            #1 drops += int'(dropped);
            check_bit("hold_valid", epoch_valid, 1'b1);
            check_bus("hold_data", epoch_i, EXP_I2);
            tick();
        end
        msv = 1'b0;
        check_int("hold_drops", drops, 5);
        handshake();
        check_bit("cont_start", start_valid, 1'b1);
        check_int("cont_cnt", int'(epoch_cnt), 2);
        cont = 1'b0;
        tick();
        send_samples(3);
        wait_epoch();
        handshake();
        check_int("cont_cnt2", int'(epoch_cnt), 3);
        check_bit("cont_idle", busy, 1'b0);

        // abort in RUN at count 2 of N=8
        do_cfg(8);
        tick();
        send_samples(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_clear", clear, 1'b1);
        check_int("abort_cnt", int'(epoch_cnt), 3);
        tick();
        check_bit("abort_clear_end", clear, 1'b0);
        ev_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            msv = (i % 2 == 1);
            #1 ev_seen = ev_seen | epoch_valid;
            tick();
        end
        msv = 1'b0;
        check_bit("abort_no_epoch", ev_seen, 1'b0);

        // abort beats a simultaneous cfg
        cfg_valid = 1'b1; spe = 16'd5; abort = 1'b1;
        tick();
        cfg_valid = 1'b0; abort = 1'b0;
        check_bit("abort_prio_busy", busy, 1'b0);

        // N=0 accepted but ignored, then N=1
        cfg_valid = 1'b1; spe = '0;
        #1 check_bit("n0_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        check_bit("n0_busy", busy, 1'b0);
        set_accum(32'h71, 32'h81);
        do_cfg(1);
        tick();
        send_samples(1);
        wait_epoch();
        handshake();
        check_int("n1_cnt", int'(epoch_cnt), 4);

        // async reset while draining
        do_cfg(2);
        tick();
        send_samples(2);
        check_bit("drain_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_ready", cfg_ready, 1'b0);
        check_bit("arst_clear_accum", clear_accum, 1'b0);
        check_int("arst_cnt", int'(epoch_cnt), 0);
        check_bus("arst_epoch_i", epoch_i, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_accum(32'h91, 32'ha1);
        do_cfg(2);
        tick();
        send_samples(2);
        wait_epoch();
        handshake();
        check_int("post_rst_cnt", int'(epoch_cnt), 1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/e1_track_epoch_ctrl.md
E1_TRACK_EPOCH_CTRL -- requirements
Module: e1_track_epoch_ctrl

Interface
REQ-001 Parameter DSIZE, default 32: sample word and accumulator width.
REQ-002 Parameter NUM_ACCUM, default 6: correlator channels VE, E, P, L, VL, Pilot, in index order 0..5.
REQ-003 Parameter CNT_W, default 16: width of the sample-count and epoch-count registers.
REQ-004 Parameter ACC_LAT, default 2: cycles from the last gated sample to stable accumulator outputs.
REQ-005 axis_aclk  in  1  sole clock; all logic on the rising edge.
REQ-006 axis_aresetn  in  1  asynchronous active-low reset.
REQ-007 i_cfg_valid / o_cfg_ready  in/out  1  epoch-configuration handshake.
REQ-008 i_samples_per_epoch  in  CNT_W  samples per integration epoch (N).
REQ-009 i_continuous  in  1  sampled at the output handshake; 1 = start the next epoch automatically.
REQ-010 i_abort  in  1  synchronous abort.
REQ-011 i_mixed_signal_valid  in  1  mixer sample strobe.
REQ-012 o_sample_valid  out  1  gated strobe to the resampler i_mixed_signal_valid.
REQ-013 o_start_tracking_valid  out  1  one-cycle pulse to the resampler.
REQ-014 o_clear  out  1  one-cycle resampler counter-clear pulse.
REQ-015 o_clear_accum  out  1  active-low accumulator clear; 0 = clear.
REQ-016 i_accum_i / i_accum_q  in  NUM_ACCUM*DSIZE  flattened resampler I/Q outputs; channel k occupies bits [k*DSIZE +: DSIZE].
REQ-017 o_epoch_i / o_epoch_q  out  NUM_ACCUM*DSIZE  latched epoch results.
REQ-018 o_epoch_valid / i_epoch_ready  out/in  1  result handshake.
REQ-019 o_epoch_cnt  out  CNT_W  count of completed epochs.
REQ-020 o_dropped  out  1  one-cycle pulse when a sample arrives outside RUN.
REQ-021 o_busy  out  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, START, RUN, DRAIN, HOLD; one-hot or binary encoding at implementer's choice.
REQ-023 IDLE behaviour:
- o_cfg_ready = 1 and o_clear_accum = 0.
- On i_cfg_valid with N != 0: latch N into n_reg and go to START.
- On i_cfg_valid with N = 0: accept the handshake but stay in IDLE.
REQ-024 START lasts exactly one cycle:
- o_start_tracking_valid = 1, o_clear_accum = 0, sample count reset to 0.
- Next state is RUN.
REQ-025 RUN behaviour:
- o_clear_accum = 1 and o_sample_valid = i_mixed_signal_valid, combinationally in the same cycle.
- The count increments on each valid sample.
- A valid sample with count = n_reg-1 is forwarded, then the state goes to DRAIN.
REQ-026 DRAIN behaviour:
- o_sample_valid = 0 and o_clear_accum = 1.
- Wait ACC_LAT cycles.
- On the final DRAIN cycle edge, register i_accum_i/q into o_epoch_i/q, set o_epoch_valid, and go to HOLD.
REQ-027 HOLD behaviour:
- o_epoch_valid and o_epoch_i/q stay stable until i_epoch_ready = 1.
- On the handshake edge: o_epoch_valid clears and o_epoch_cnt increments, wrapping 2^CNT_W-1 -> 0.
- Then go to START if i_continuous = 1 (reuse n_reg), else IDLE.
REQ-028 o_sample_valid is 0 in every state except RUN.
REQ-029 Dropped samples: i_mixed_signal_valid in any state other than RUN produces an o_dropped pulse in the same cycle; the sample is not forwarded.
REQ-030 i_abort from any state, effective next edge:
- State goes to IDLE, o_epoch_valid goes to 0, o_clear pulses for one cycle, o_epoch_cnt is unchanged.
- Abort has priority over all simultaneous events, including cfg and ready handshakes.
REQ-031 The sample count is CNT_W bits and never wraps; N = 2^CNT_W-1 is supported.
REQ-032 In IDLE, i_epoch_ready is ignored.

Reset
REQ-033 While axis_aresetn = 0:
- State = IDLE, and n_reg, count and o_epoch_cnt = 0.
- o_epoch_i/q = 0.
- o_epoch_valid, o_sample_valid, o_start_tracking_valid, o_clear, o_dropped and o_busy = 0.
- o_clear_accum = 0 (accumulators held clear).
- o_cfg_ready = 0.
REQ-034 o_cfg_ready goes to 1 on the first clock edge after reset deassertion.
REQ-035 Reset asserted mid-epoch discards the epoch with no result output.

Structure
REQ-036 State encoding and the default values of DSIZE, NUM_ACCUM, CNT_W and ACC_LAT live in the shared tracking package.
REQ-037 The design is a single module with no sub-modules; it instantiates neither the resampler nor the accumulators.

Verification
REQ-038 Basic epoch: cfg N=4, 4 contiguous valids, accumulators driven with values 0x11..0x16:
- 1-cycle start pulse, then 4 o_sample_valid.
- o_epoch_valid 1+ACC_LAT cycles after the last sample, o_epoch_i = driven values.
- o_epoch_cnt 0 -> 1 after ready.
REQ-039 Back-pressure and continuous: i_continuous = 1, i_epoch_ready held low for 10 cycles:
- o_epoch_valid and data stay stable, and samples in HOLD pulse o_dropped.
- After ready, the next START occurs in the following cycle.
REQ-040 Abort: i_abort in RUN at count 2 of N=8:
- Next cycle IDLE, o_clear pulse, o_epoch_valid never rises, o_epoch_cnt unchanged.
REQ-041 N=0 cfg: the handshake completes and the block stays in IDLE with o_busy = 0; then N=1 with a single sample yields one epoch.
REQ-042 Async reset asserted in DRAIN: all outputs go to their reset values immediately; after release, a fresh cfg N=2 completes normally.
